// File: rtl/user_input_arbiter.sv
// Round-robin arbiter granting one shared resource to N latched key-press requesters,
// with a per-grant watchdog that revokes a grant never answered by done.
module user_input_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] owner,
    output logic [N-1:0]         pending,
    output logic                 timeout_err
);

    localparam int OW = $clog2(N);
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t        state_reg, state_next;
    logic [N-1:0]  pending_reg, pending_next;
    logic [N-1:0]  grant_reg, grant_next;
    logic [OW-1:0] owner_reg, owner_next;
    logic [OW-1:0] last_owner_reg, last_owner_next;
    logic [7:0]    wd_reg, wd_next;
    logic          terr_reg, terr_next;

    logic          pick_found;
    logic [OW-1:0] pick_idx;
    logic          grant_take;

    // Index base+k wrapped into 0..N-1; k never exceeds N so one subtraction suffices.
    function automatic logic [OW-1:0] wrap_idx(input logic [OW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return OW'(s);
    endfunction

    // Scan from farthest to nearest so the nearest pending requester after last_owner wins.
    always_comb begin
        logic [OW-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = N; k >= 1; k--) begin
            cand = wrap_idx(last_owner_reg, k);
            if (pending_reg[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg      <= IDLE;
            pending_reg    <= '0;
            grant_reg      <= '0;
            owner_reg      <= '0;
            last_owner_reg <= OW'(N - 1);
            wd_reg         <= '0;
            terr_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pending_reg    <= pending_next;
            grant_reg      <= grant_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            wd_reg         <= wd_next;
            terr_reg       <= terr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pick_found) state_next = GRANT;
            GRANT:   if (done || wd_reg == WD_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // done takes precedence over the watchdog when both land on the same edge.
    always_comb begin
        grant_next      = grant_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        wd_next         = wd_reg;
        terr_next       = 1'b0;
        grant_take      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    grant_take = 1'b1;
                    owner_next = pick_idx;
                    grant_next = ONE_N << pick_idx;
                    wd_next    = '0;
                end
            end
            GRANT: begin
                if (done) begin
                    grant_next      = '0;
                    last_owner_next = owner_reg;
                end else if (wd_reg == WD_LAST) begin
                    grant_next      = '0;
                    last_owner_next = owner_reg;
                    terr_next       = 1'b1;
                end else begin
                    wd_next = wd_reg + 8'd1;
                end
            end
            default: begin
                grant_next = '0;
            end
        endcase
    end

    // A press landing on the edge that grants the same requester keeps its pending bit.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pending
            logic clear_bit;
            assign clear_bit        = grant_take && (pick_idx == OW'(gi));
            assign pending_next[gi] = req[gi] | (pending_reg[gi] & ~clear_bit);
        end
    endgenerate

    assign grant       = grant_reg;
    assign grant_valid = (state_reg == GRANT);
    assign owner       = owner_reg;
    assign pending     = pending_reg;
    assign timeout_err = terr_reg;

endmodule

// File: tb/tb_user_input_arbiter.sv
// Directed and randomized checks of user_input_arbiter against a cycle-level behavioural model.
module tb_user_input_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 8;
    localparam int OW      = $clog2(N);

    logic          Clock;
    logic          Reset;
    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [OW-1:0] owner;
    logic [N-1:0]  pending;
    logic          timeout_err;

    int tests = 0;
    int fails = 0;

    // Behavioural model: busy flag, owner, last owner, cycles held so far.
    logic [N-1:0] m_pending;
    logic         m_busy;
    int           m_owner;
    int           m_last;
    int           m_held;
    logic         m_terr;

    user_input_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .owner       (owner),
        .pending     (pending),
        .timeout_err (timeout_err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL tb_timeout: observed simulation still running, expected finish");
        $fatal(1, "tb time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pending = '0;
        m_busy    = 1'b0;
        m_owner   = 0;
        m_last    = N - 1;
        m_held    = 0;
        m_terr    = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic d);
        logic [N-1:0] np;
        int pick;
        np     = m_pending | r;
        m_terr = 1'b0;
        pick   = 0;
        if (!m_busy) begin
            if (m_pending != '0) begin
                for (int i = 1; i <= N; i++) begin
                    if (m_pending[(m_last + i) % N]) begin
                        pick = (m_last + i) % N;
                        break;
                    end
                end
                m_busy  = 1'b1;
                m_owner = pick;
                m_held  = 1;
                if (!r[pick]) np[pick] = 1'b0;
            end
        end else if (d) begin
            m_busy = 1'b0;
            m_last = m_owner;
        end else if (m_held == TIMEOUT) begin
            m_busy = 1'b0;
            m_last = m_owner;
            m_terr = 1'b1;
        end else begin
            m_held++;
        end
        m_pending = np;
    endtask

    task automatic compare_model();
        logic [N-1:0] g;
        g = m_busy ? (N'(1) << m_owner) : '0;
        chk("grant", 32'(grant), 32'(g));
        chk("grant_valid", 32'(grant_valid), 32'(m_busy));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("pending", 32'(pending), 32'(m_pending));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    endtask

    task automatic tick(input logic [N-1:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge Clock);
        model_step(r, d);
        #1;
        $display("[TB] t=%0t req=%b done=%b grant=%b gv=%b owner=%0d pending=%b terr=%b",
                 $time, r, d, grant, grant_valid, owner, pending, timeout_err);
        req  = '0;
        done = 1'b0;
        compare_model();
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        req   = '1;
        done  = 1'b0;
        model_reset();
        #1;
        compare_model();
        repeat (2) begin
            @(posedge Clock);
            #1;
            compare_model();
        end
        Reset = 1'b1;
        req   = '0;
    endtask

    initial begin
        int high_cnt;
        logic [N-1:0] r;
        Reset = 1'b0;
        req   = '0;
        done  = 1'b0;

        // Reset with all keys held, then a single press from requester 0.
        do_reset();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_gv", 32'(grant_valid), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        tick(4'b0001, 1'b0);
        chk("rst_pend1", 32'(pending), 32'h1);
        tick(4'b0000, 1'b0);
        chk("rst_grant1", 32'(grant), 32'h1);
        tick(4'b0000, 1'b1);

        // Single request from requester 2, done on edge 5.
        tick(4'b0100, 1'b0);
        chk("single_pend", 32'(pending), 32'h4);
        tick(4'b0000, 1'b0);
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_owner", 32'(owner), 32'd2);
        chk("single_pend_clr", 32'(pending), 32'h0);
        tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b1);
        chk("single_done", 32'(grant), 32'h0);

        // All four press together; grants rotate 0..3 with an idle cycle between.
        do_reset();
        tick(4'b1111, 1'b0);
        for (int j = 0; j < N; j++) begin
            tick(4'b0000, 1'b0);
            chk("all_owner", 32'(owner), 32'(j));
            chk("all_gv", 32'(grant_valid), 32'h1);
            tick(4'b0000, 1'b0);
            tick(4'b0000, 1'b1);
            chk("all_idle", 32'(grant_valid), 32'h0);
        end

        // Requester 1 re-presses during its own grant and is queued behind 3 and 0.
        do_reset();
        tick(4'b0010, 1'b0);
        tick(4'b0000, 1'b0);
        chk("rq_owner1", 32'(owner), 32'd1);
        tick(4'b1001, 1'b0);
        chk("rq_pend", 32'(pending), 32'h9);
        tick(4'b0010, 1'b0);
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b0);
        chk("rq_next3", 32'(owner), 32'd3);
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b0);
        chk("rq_next0", 32'(owner), 32'd0);
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b0);
        chk("rq_next1", 32'(owner), 32'd1);
        tick(4'b0000, 1'b1);

        // Press on the very edge that grants the same requester: set wins.
        do_reset();
        tick(4'b0100, 1'b0);
        tick(4'b0100, 1'b0);
        chk("sw_owner", 32'(owner), 32'd2);
        chk("sw_pend", 32'(pending[2]), 32'h1);
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b0);
        chk("sw_regrant", 32'(grant), 32'h4);
        tick(4'b0000, 1'b1);

        // Watchdog revoke after TIMEOUT cycles, then pending requester 1 served.
        do_reset();
        tick(4'b0001, 1'b0);
        tick(4'b0000, 1'b0);
        tick(4'b0010, 1'b0);
        high_cnt = 2;
        for (int i = 0; i < 20 && grant_valid; i++) begin
            tick(4'b0000, 1'b0);
            if (grant_valid) high_cnt++;
        end
        chk("wd_cycles", 32'(high_cnt), 32'(TIMEOUT));
        chk("wd_terr", 32'(timeout_err), 32'h1);
        tick(4'b0000, 1'b0);
        chk("wd_terr_pulse", 32'(timeout_err), 32'h0);
        chk("wd_next_owner", 32'(owner), 32'd1);
        tick(4'b0000, 1'b1);

        // done on the revoke edge suppresses timeout_err; then async reset mid-grant.
        do_reset();
        tick(4'b0001, 1'b0);
        tick(4'b0000, 1'b0);
        tick(4'b0010, 1'b0);
        repeat (TIMEOUT - 2) tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b1);
        chk("wd_done_gv", 32'(grant_valid), 32'h0);
        chk("wd_done_terr", 32'(timeout_err), 32'h0);
        tick(4'b0000, 1'b0);
        chk("mid_owner", 32'(owner), 32'd1);
        #3;
        Reset = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_gv", 32'(grant_valid), 32'h0);
        chk("mid_rst_terr", 32'(timeout_err), 32'h0);
        do_reset();

        // Random presses and done responses against the model.
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 4) == 0);
            tick(r, ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/user_input_arbiter.md
# user_input_arbiter

Round-robin arbiter that shares one downstream resource among `N` user-input requesters, such as a score/display update unit driven by several players' keys. Each requester supplies one-cycle press pulses from its key edge detector. The arbiter latches each press as a pending request and grants the resource to one requester at a time. It holds the grant until the resource signals `done`, or until a watchdog timeout expires. It sits between the per-key edge detectors and the shared datapath.

## Interface
- `N`, 4: number of requesters (2..8).
- `TIMEOUT`, 255: maximum cycles a grant may be held without `done`, range 2..255.
- `Clock` input, 1: system clock; all state changes on rising edge.
- `Reset` input, 1: asynchronous, active-low reset (0 = reset asserted).
- `req` input, N: one-cycle press pulses, one bit per requester.
- `done` input, 1: resource finished the current owner's transaction; sampled only while `grant_valid`=1.
- `grant` output, N: one-hot grant vector; all zero when no grant is held.
- `grant_valid` output, 1: a grant is currently held.
- `owner` output, `$clog2(N)`: index of the current grantee; holds its last value when idle.
- `pending` output, N: latched, not-yet-granted requests.
- `timeout_err` output, 1: one-cycle pulse when a grant is revoked by the watchdog.

## Operation
- Reset (asynchronous, while `Reset`=0) clears the following immediately:
  - `grant`=0, `grant_valid`=0, `owner`=0, `pending`=0, `timeout_err`=0.
  - State returns to IDLE and the watchdog counter clears to 0.
  - The internal last-owner pointer is set to N-1, so requester 0 has first priority.
- Pending latch, per bit `i`:
  - `req[i]`=1 on an edge sets `pending[i]`.
  - Entering GRANT with owner `i` clears `pending[i]`.
  - If the set and the clear occur on the same edge, set wins and `pending[i]` stays 1.
  - A press while already pending is absorbed; there is no counting.
- State machine, two states:
  - IDLE: if `pending`≠0, pick the first set bit scanning from last_owner+1 upward, modulo N. Load `owner` and `grant`, set `grant_valid`, clear that pending bit, clear the watchdog, and go to GRANT. If `pending`=0, stay in IDLE. `done` is ignored in IDLE.
  - GRANT: `grant` and `owner` are held stable. The watchdog increments each cycle.
  - GRANT with `done`=1: go to IDLE, clear `grant` and `grant_valid`, and set last_owner=`owner`.
  - GRANT with `done`=0 and watchdog = TIMEOUT-1: go to IDLE, clear the grant, set last_owner=`owner`, and pulse `timeout_err` for one cycle.
  - If `done` arrives on the same edge as the timeout, `done` wins and there is no `timeout_err`.
- Fairness:
  - A requester re-pressing during its own grant is re-queued behind every other pending requester.
  - Worst-case wait is (N-1) grants.
- Width rules:
  - The watchdog is 8 bits and never wraps; it saturates at the revoke point.
  - The pointer increments modulo N, including for non-power-of-two N.

## Timing
- `req` pulse sampled on edge k: `pending` is set after edge k, the earliest grant appears after edge k+1, so latency is 2 edges.
- `done` sampled on edge m: `grant_valid`=0 after edge m.
- Between consecutive grants there is at least one IDLE cycle with `grant_valid`=0.
- A grant lasts at most TIMEOUT cycles.
- `timeout_err` is high for exactly the one cycle following the revoke edge.
- Outputs are registered with no combinational path from inputs to outputs.
- `Reset` asserted mid-grant drops `grant` asynchronously, with no `timeout_err`. Pending requests are lost.

## Test plan
- Reset: hold `Reset`=0 for 2 edges with `req`=1111 → all outputs 0. Release, then pulse `req`=0001 → `pending`=0001 after the next edge and `grant`=0001 after the following edge.
- Single request: pulse `req[2]` at edge 1 and assert `done` at edge 5.
  - Required: `pending`=0100 after edge 1, then `grant`=0100, `owner`=2, `pending`=0000 after edge 2.
  - Required: `grant`=0 after edge 5.
- All simultaneous: pulse `req`=1111 after reset and return `done` 2 cycles into each grant → owners granted in order 0,1,2,3, with one idle cycle between grants.
- Re-queue: pulse `req[1]` during owner 1's grant while `pending`=1001 → next grants go to 3, then 0, then 1.
- Set-wins: pulse `req[2]` on the same edge that grants owner 2 → `pending[2]`=1 after that edge, and owner 2 is granted again after its current `done`.
- Watchdog with `TIMEOUT`=8: grant owner 0 and never assert `done` → grant revoked after 8 GRANT cycles, `timeout_err` pulses once, and pending owner 1 is granted next. A repeat run with `done` on the revoke edge → no `timeout_err`.
